uart_apb_arbiter: RTL and testbench

- Two-requester APB master that shares the single UART register-interface APB slave between two clients, e.g. the CPU bridge (port 0) and an RX-drain/DMA engine (port 1).
- Accepts one command per requester at a time, arbitrates round-robin, and drives fixed two-phase APB transfers (SETUP, ACCESS) with no wait states.
- Returns read data or write completion to the owning requester.
- Enforces the minimum idle gap the UART TX-write path needs between a TX-data write and the next transfer.

---
 rtl/uart_apb_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_uart_apb_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_apb_arbiter.sv
// rtl/uart_apb_arbiter.sv - two-requester round-robin APB master for the UART register slave
//
// Ports:
//   clk, rst_                    clock; synchronous active-high reset
//   reqN_valid/write/addr/wdata  command from requester N (N = 0, 1), held until reqN_ready
//   reqN_ready                   one-cycle accept pulse, high in the SETUP cycle
//   respN_valid/respN_rdata      one-cycle completion pulse; read data (0 for writes), held
//   paddr_o/pwdata_o/pwrite_o    APB address/data/direction, hold their value when idle
//   psel_o/penable_o             APB select/enable
//   prdata_i                     APB read data, sampled at the end of ACCESS
module uart_apb_arbiter #(
  parameter int         TX_GAP    = 1,
  parameter logic [3:0] TX_OFFSET = 4'h0
) (
  input  logic        clk,
  input  logic        rst_,
  input  logic        req0_valid,
  input  logic        req0_write,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        req0_ready,
  output logic        resp0_valid,
  output logic [31:0] resp0_rdata,
  input  logic        req1_valid,
  input  logic        req1_write,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        req1_ready,
  output logic        resp1_valid,
  output logic [31:0] resp1_rdata,
  output logic [31:0] paddr_o,
  output logic [31:0] pwdata_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  input  logic [31:0] prdata_i
);

  localparam int GW = (TX_GAP > 1) ? $clog2(TX_GAP + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_GAP} state_t;

  state_t          r_state;
  logic            r_owner;
  logic            r_last_grant;
  logic [GW-1:0]   r_gap_cnt;
  logic            r_req0_ready;
  logic            r_req1_ready;
  logic            r_resp0_valid;
  logic            r_resp1_valid;
  logic [31:0]     r_resp0_rdata;
  logic [31:0]     r_resp1_rdata;
  logic [31:0]     r_paddr;
  logic [31:0]     r_pwdata;
  logic            r_psel;
  logic            r_penable;
  logic            r_pwrite;

  logic            w_tx_write;
  logic            w_gap_last;
  logic            w_arb_open;
  logic            w_any;
  logic            w_pick;
  logic            w_start;

  // The latched command is what is on the bus, so decode the gap from it.
  assign w_tx_write = r_pwrite && (r_paddr[5:2] == TX_OFFSET) && (TX_GAP > 0);
  assign w_gap_last = (r_gap_cnt <= GW'(1));

  // The last GAP cycle doubles as the idle arbitration point, so exactly
  // TX_GAP deselected cycles separate a TX write from the next SETUP.
  always_comb begin
    w_arb_open = 1'b0;
    case (r_state)
      S_IDLE:   w_arb_open = 1'b1;
      S_ACCESS: w_arb_open = !w_tx_write;
      S_GAP:    w_arb_open = w_gap_last;
      default:  w_arb_open = 1'b0;
    endcase
  end

  assign w_any   = req0_valid | req1_valid;
  // Single requester wins outright; a tie goes to the one not served last.
  assign w_pick  = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;
  assign w_start = w_arb_open & w_any;

  always_ff @(posedge clk) begin
    if (rst_) begin
      r_state       <= S_IDLE;
      r_owner       <= 1'b0;
      r_last_grant  <= 1'b1;
      r_gap_cnt     <= '0;
      r_req0_ready  <= 1'b0;
      r_req1_ready  <= 1'b0;
      r_resp0_valid <= 1'b0;
      r_resp1_valid <= 1'b0;
      r_resp0_rdata <= '0;
      r_resp1_rdata <= '0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
    end else begin
      r_req0_ready  <= 1'b0;
      r_req1_ready  <= 1'b0;
      r_resp0_valid <= 1'b0;
      r_resp1_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
        end
        S_SETUP: begin
          r_state   <= S_ACCESS;
          r_penable <= 1'b1;
        end
        S_ACCESS: begin
          if (r_owner == 1'b0) begin
            r_resp0_valid <= 1'b1;
            r_resp0_rdata <= r_pwrite ? 32'h0 : prdata_i;
          end else begin
            r_resp1_valid <= 1'b1;
            r_resp1_rdata <= r_pwrite ? 32'h0 : prdata_i;
          end
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
          if (w_tx_write) begin
            r_state   <= S_GAP;
            r_gap_cnt <= GW'(TX_GAP);
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_GAP: begin
          if (r_gap_cnt != '0) begin
            r_gap_cnt <= r_gap_cnt - GW'(1);
          end
          if (w_gap_last) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // A grant overrides whatever the state branch chose for the next cycle.
      if (w_start) begin
        r_state      <= S_SETUP;
        r_psel       <= 1'b1;
        r_penable    <= 1'b0;
        r_owner      <= w_pick;
        r_last_grant <= w_pick;
        if (w_pick == 1'b0) begin
          r_paddr      <= req0_addr;
          r_pwdata     <= req0_wdata;
          r_pwrite     <= req0_write;
          r_req0_ready <= 1'b1;
        end else begin
          r_paddr      <= req1_addr;
          r_pwdata     <= req1_wdata;
          r_pwrite     <= req1_write;
          r_req1_ready <= 1'b1;
        end
      end
    end
  end

  assign req0_ready  = r_req0_ready;
  assign req1_ready  = r_req1_ready;
  assign resp0_valid = r_resp0_valid;
  assign resp1_valid = r_resp1_valid;
  assign resp0_rdata = r_resp0_rdata;
  assign resp1_rdata = r_resp1_rdata;
  assign paddr_o     = r_paddr;
  assign pwdata_o    = r_pwdata;
  assign psel_o      = r_psel;
  assign penable_o   = r_penable;
  assign pwrite_o    = r_pwrite;

endmodule

// File: tb/tb_uart_apb_arbiter.sv
// tb/tb_uart_apb_arbiter.sv - directed self-checking bench for uart_apb_arbiter
module tb_uart_apb_arbiter;

  logic        clk = 1'b0;
  logic        rst_ = 1'b1;
  logic        req0_valid = 1'b0, req0_write = 1'b0;
  logic [31:0] req0_addr = '0, req0_wdata = '0;
  logic        req0_ready, resp0_valid;
  logic [31:0] resp0_rdata;
  logic        req1_valid = 1'b0, req1_write = 1'b0;
  logic [31:0] req1_addr = '0, req1_wdata = '0;
  logic        req1_ready, resp1_valid;
  logic [31:0] resp1_rdata;
  logic [31:0] paddr_o, pwdata_o, prdata_i = '0;
  logic        psel_o, penable_o, pwrite_o;

  int total = 0;
  int bad   = 0;
  int order[$];
  logic rr_mon = 1'b0;

  always #5 clk = ~clk;

  uart_apb_arbiter #(.TX_GAP(1), .TX_OFFSET(4'h0)) dut (
    .clk(clk), .rst_(rst_),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .resp0_valid(resp0_valid),
    .resp0_rdata(resp0_rdata),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .resp1_valid(resp1_valid),
    .resp1_rdata(resp1_rdata),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o), .psel_o(psel_o),
    .penable_o(penable_o), .pwrite_o(pwrite_o), .prdata_i(prdata_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int id, input logic v, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
    if (id == 0) begin
      req0_valid = v; req0_write = w; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = v; req1_write = w; req1_addr = a; req1_wdata = d;
    end
  endtask

  function automatic logic rdy(input int id);
    return (id == 0) ? req0_ready : req1_ready;
  endfunction

  function automatic logic rsp(input int id);
    return (id == 0) ? resp0_valid : resp1_valid;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_ = 1'b1;
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    prdata_i = '0;
    repeat (2) @(negedge clk);
    rst_ = 1'b0;
  endtask

  task automatic run_req(input int id, input int n);
    int cnt;
    for (int k = 0; k < n; k++) begin
      set_req(id, 1, 0, (id == 0) ? 32'h04 : 32'h08, 0);
      cnt = 0;
      @(negedge clk);
      while (!rdy(id) && cnt < 40) begin @(negedge clk); cnt++; end
      if (!rdy(id)) check("rr_ready_timeout", 0, 1);
      set_req(id, 0, 0, 0, 0);
      cnt = 0;
      @(negedge clk);
      while (!rsp(id) && cnt < 40) begin @(negedge clk); cnt++; end
      if (!rsp(id)) check("rr_resp_timeout", 0, 1);
    end
  endtask

  always @(negedge clk) begin
    if (rr_mon) begin
      if (req0_ready) order.push_back(0);
      if (req1_ready) order.push_back(1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // reset state
    do_reset();
    check("rst_psel", psel_o, 0);
    check("rst_penable", penable_o, 0);
    check("rst_ready0", req0_ready, 0);
    check("rst_resp1", resp1_valid, 0);
    check("rst_paddr", paddr_o, 0);

    // single read of 0x1C
    set_req(0, 1, 0, 32'h1C, 0);
    @(negedge clk);
    check("rd_ready0", req0_ready, 1);
    check("rd_setup_psel", psel_o, 1);
    check("rd_setup_pen", penable_o, 0);
    check("rd_paddr", paddr_o, 32'h1C);
    set_req(0, 0, 0, 0, 0);
    prdata_i = 32'h5;
    @(negedge clk);
    check("rd_access_pen", penable_o, 1);
    check("rd_access_ready0", req0_ready, 0);
    @(negedge clk);
    check("rd_resp0", resp0_valid, 1);
    check("rd_rdata", resp0_rdata, 32'h5);
    check("rd_idle_psel", psel_o, 0);
    @(negedge clk);
    check("rd_resp0_drop", resp0_valid, 0);
    check("rd_rdata_hold", resp0_rdata, 32'h5);

    // simultaneous after reset
    do_reset();
    set_req(0, 1, 0, 32'h04, 0);
    set_req(1, 1, 0, 32'h08, 0);
    prdata_i = 32'hA0;
    @(negedge clk);
    check("sim_ready0", req0_ready, 1);
    check("sim_ready1_wait", req1_ready, 0);
    check("sim_paddr0", paddr_o, 32'h04);
    set_req(0, 0, 0, 0, 0);
    @(negedge clk);
    check("sim_access0", penable_o, 1);
    @(negedge clk);
    check("sim_ready1", req1_ready, 1);
    check("sim_b2b_psel", psel_o, 1);
    check("sim_b2b_pen", penable_o, 0);
    check("sim_paddr1", paddr_o, 32'h08);
    check("sim_resp0", resp0_valid, 1);
    check("sim_rdata0", resp0_rdata, 32'hA0);
    set_req(1, 0, 0, 0, 0);
    prdata_i = 32'hB1;
    @(negedge clk);
    check("sim_access1", penable_o, 1);
    check("sim_resp0_drop", resp0_valid, 0);
    @(negedge clk);
    check("sim_resp1", resp1_valid, 1);
    check("sim_rdata1", resp1_rdata, 32'hB1);

    // round-robin with both requesters re-requesting
    do_reset();
    order.delete();
    rr_mon = 1'b1;
    fork
      run_req(0, 3);
      run_req(1, 3);
    join
    rr_mon = 1'b0;
    check("rr_count", order.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("rr_grant%0d", i),
            (i < order.size()) ? 32'(order[i]) : 32'hFFFF, 32'(i % 2));
    end

    // TX gap: write to 0x00 forces one idle cycle
    do_reset();
    set_req(0, 1, 1, 32'h00, 32'h41);
    set_req(1, 1, 1, 32'h00, 32'h42);
    @(negedge clk);
    check("gap_ready0", req0_ready, 1);
    check("gap_pwdata0", pwdata_o, 32'h41);
    set_req(0, 0, 0, 0, 0);
    @(negedge clk);
    check("gap_access0", penable_o, 1);
    @(negedge clk);
    check("gap_idle_psel", psel_o, 0);
    check("gap_no_ready1", req1_ready, 0);
    check("gap_resp0_rdata", resp0_rdata, 0);
    @(negedge clk);
    check("gap_setup1_psel", psel_o, 1);
    check("gap_ready1", req1_ready, 1);
    check("gap_pwdata1", pwdata_o, 32'h42);
    set_req(1, 0, 0, 0, 0);
    repeat (3) @(negedge clk);

    // write to 0x08: no gap
    do_reset();
    set_req(0, 1, 1, 32'h08, 32'h55);
    set_req(1, 1, 1, 32'h08, 32'h66);
    @(negedge clk);
    set_req(0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    check("nogap_psel", psel_o, 1);
    check("nogap_ready1", req1_ready, 1);
    check("nogap_pwdata1", pwdata_o, 32'h66);
    set_req(1, 0, 0, 0, 0);
    repeat (3) @(negedge clk);

    // write response for requester 1
    do_reset();
    set_req(1, 1, 1, 32'h0C, 32'h34);
    @(negedge clk);
    check("wr_ready1", req1_ready, 1);
    check("wr_setup_pwrite", pwrite_o, 1);
    check("wr_setup_pwdata", pwdata_o, 32'h34);
    check("wr_setup_paddr", paddr_o, 32'h0C);
    set_req(1, 0, 0, 0, 0);
    prdata_i = 32'hDEAD;
    @(negedge clk);
    check("wr_access_pen", penable_o, 1);
    check("wr_access_pwrite", pwrite_o, 1);
    check("wr_access_pwdata", pwdata_o, 32'h34);
    @(negedge clk);
    check("wr_resp1", resp1_valid, 1);
    check("wr_rdata1", resp1_rdata, 0);
    check("wr_resp0_quiet", resp0_valid, 0);

    // reset during ACCESS
    do_reset();
    set_req(0, 1, 0, 32'h14, 0);
    @(negedge clk);
    set_req(0, 0, 0, 0, 0);
    @(negedge clk);
    check("mid_in_access", penable_o, 1);
    rst_ = 1'b1;
    @(negedge clk);
    check("mid_psel", psel_o, 0);
    check("mid_penable", penable_o, 0);
    check("mid_no_resp", resp0_valid, 0);
    rst_ = 1'b0;
    @(negedge clk);
    check("mid_no_resp_late", resp0_valid, 0);
    set_req(0, 1, 0, 32'h18, 0);
    set_req(1, 1, 0, 32'h1C, 0);
    @(negedge clk);
    check("mid_regrant0", req0_ready, 1);
    check("mid_regrant_not1", req1_ready, 0);
    // requester 1 withdraws before being granted: must be ignored
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    check("drop_no_ready1", req1_ready, 0);
    check("drop_resp0", resp0_valid, 1);
    @(negedge clk);
    check("drop_idle", psel_o, 0);
    @(negedge clk);
    check("drop_no_resp1", resp1_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
